fir_lowpass_filter: RTL and testbench



---
 rtl/fir_lowpass_filter_if.sv | 11 +
 rtl/fir_lowpass_filter.sv | 57 +++++
 tb/tb_fir_lowpass_filter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fir_lowpass_filter_if.sv
// Sample stream bundle for the FIR: input sample in, full-precision filter sum out.
interface fir_lowpass_filter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 32
);
  logic signed [DATA_WIDTH-1:0] data_in;
  logic signed [OUT_WIDTH-1:0]  data_out;

  modport master (output data_in, input data_out);
  modport slave  (input data_in, output data_out);
endinterface

// File: rtl/fir_lowpass_filter.sv
// 16-tap symmetric lowpass FIR, one sample per clock, exact Q1.15 sum of products.
// Output is registered; a sample's h[k] term shows on data_out k+1 edges after capture.
module fir_lowpass_filter #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 32
) (
  input logic                  clk,
  input logic                  rst,
  fir_lowpass_filter_if.slave  bus
);

  localparam int NUM_TAPS   = 16;
  localparam int COEF_WIDTH = 16;
  localparam int NUM_HALF   = NUM_TAPS / 2;
  localparam int PRE_WIDTH  = DATA_WIDTH + 1;

  // First half of the impulse response; the second half mirrors it.
  localparam logic signed [COEF_WIDTH-1:0] COEF [NUM_HALF] = '{
    -16'sd120, -16'sd280, -16'sd310, 16'sd0,
    16'sd820, 16'sd2150, 16'sd3600, 16'sd4600
  };

  logic signed [DATA_WIDTH-1:0] r_taps [NUM_TAPS];
  logic signed [OUT_WIDTH-1:0]  r_data_out;

  logic signed [PRE_WIDTH-1:0]  w_pre  [NUM_HALF];
  logic signed [OUT_WIDTH-1:0]  w_prod [NUM_HALF];
  logic signed [OUT_WIDTH-1:0]  w_sum;

  // Pre-add mirrored taps, then one multiply per coefficient pair.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NUM_HALF; k++) begin
      w_pre[k]  = PRE_WIDTH'(r_taps[k]) + PRE_WIDTH'(r_taps[NUM_TAPS-1-k]);
      w_prod[k] = OUT_WIDTH'(w_pre[k]) * OUT_WIDTH'(COEF[k]);
      w_sum     = w_sum + w_prod[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_taps[k] <= '0;
      end
      r_data_out <= '0;
    end else begin
      r_taps[0] <= bus.data_in;
      for (int k = 1; k < NUM_TAPS; k++) begin
        r_taps[k] <= r_taps[k-1];
      end
      r_data_out <= w_sum;
    end
  end

  assign bus.data_out = r_data_out;

endmodule

// File: tb/tb_fir_lowpass_filter.sv
// Bench for fir_lowpass_filter: convolution model checked every cycle plus directed literals.
module tb_fir_lowpass_filter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fir_lowpass_filter_if #(.DATA_WIDTH(16), .OUT_WIDTH(32)) bus ();

  fir_lowpass_filter #(.DATA_WIDTH(16), .OUT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int h [16] = '{-120, -280, -310, 0, 820, 2150, 3600, 4600,
                 4600, 3600, 2150, 820, 0, -310, -280, -120};

  longint imp [16] = '{-120, -280, -310, 0, 820, 2150, 3600, 4600,
                       4600, 3600, 2150, 820, 0, -310, -280, -120};

  // Model: history of captured samples (newest at back); output is their convolution with h.
  longint hist [$];
  longint exp_out = 0;
  longint acc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist.delete();
      exp_out <= 0;
    end else begin
      acc = 0;
      for (int k = 0; k < 16; k++) begin
        if (k < hist.size()) acc = acc + longint'(h[k]) * hist[hist.size()-1-k];
      end
      exp_out <= acc;
      hist.push_back(longint'(bus.data_in));
      if (hist.size() > 16) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    n_checks++;
    if (longint'(bus.data_out) != exp_out) begin
      n_errors++;
      $display("FAIL model_compare t=%0t data_out=%0d expected=%0d", $time, bus.data_out,
               exp_out);
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s t=%0t data_out=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input int v);
    bus.data_in = 16'(v);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b0;
    #1 check("reset_async_clear", longint'(bus.data_out), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  longint worst;

  initial begin
    bus.data_in = 16'sd12345;
    #2 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("reset_hold", longint'(bus.data_out), 0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("release_empty", longint'(bus.data_out), 0);
    @(negedge clk);
    check("release_h0", longint'(bus.data_out), -1481400);

    // Impulse response
    repeat (16) cycle(0);
    cycle(1);
    check("impulse_capture", longint'(bus.data_out), 0);
    for (int k = 0; k < 16; k++) begin
      cycle(0);
      check($sformatf("impulse_h%0d", k), longint'(bus.data_out), imp[k]);
    end
    repeat (4) cycle(0);
    check("impulse_tail", longint'(bus.data_out), 0);

    // Step with a mid-stream reset after output 8
    for (int i = 0; i < 8; i++) begin
      cycle(1000);
      if (i == 1) check("step_first", longint'(bus.data_out), -120000);
    end
    pulse_reset();
    cycle(1000);
    check("restart_empty", longint'(bus.data_out), 0);
    cycle(1000);
    check("restart_h0", longint'(bus.data_out), -120000);
    repeat (18) cycle(1000);
    check("step_steady", longint'(bus.data_out), 20920000);

    // Negative full scale
    pulse_reset();
    repeat (20) cycle(-32768);
    check("neg_full_scale", longint'(bus.data_out), -685506560);

    // Worst-case magnitude: sign of each sample matches its coefficient
    pulse_reset();
    for (int j = 0; j < 16; j++) begin
      cycle(h[j] > 0 ? 32767 : (h[j] < 0 ? -32768 : 0));
    end
    cycle(0);
    worst = 64'sd32767 * 64'sd22340 + 64'sd32768 * 64'sd1420;
    check("worst_case", longint'(bus.data_out), worst);
    check("worst_case_literal", longint'(bus.data_out), 778545340);
    repeat (20) cycle(0);
    check("drain_zero", longint'(bus.data_out), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
